// File: rtl/cypher_if.sv
// Signal bundle between the cypher-detect control unit (master) and its datapath (slave).
interface cypher_if #(
  parameter int NIBBLE_W    = 4,
  parameter int NIBBLES     = 4,
  parameter int MATCH_CNT_W = 8
);
  localparam int CW = NIBBLE_W * NIBBLES;

  logic [CW-1:0]          cypher_in;
  logic                   cypher_register_enable;
  logic [NIBBLE_W-1:0]    nibble_in;
  logic                   nibble_valid;
  logic                   input_register_enable;
  logic                   compare_enable;
  logic                   output_enable;

  logic                   armed;
  logic                   window_full;
  logic                   match;
  logic                   match_seen;
  logic [MATCH_CNT_W-1:0] match_count;
  logic [CW-1:0]          data_out;
  logic                   out_valid;
  logic                   locked;

  modport master (
    output cypher_in, cypher_register_enable, nibble_in, nibble_valid,
           input_register_enable, compare_enable, output_enable,
    input  armed, window_full, match, match_seen, match_count, data_out,
           out_valid, locked
  );

  modport slave (
    input  cypher_in, cypher_register_enable, nibble_in, nibble_valid,
           input_register_enable, compare_enable, output_enable,
    output armed, window_full, match, match_seen, match_count, data_out,
           out_valid, locked
  );
endinterface

// File: rtl/cypher_datapath.sv
// Cypher capture, sliding nibble window, compare and output register for the cypher-detect unit.
// Define CYPHER_MISMATCH_LOCK_EN to add the three-consecutive-miss lockout state.
module cypher_datapath #(
  parameter int NIBBLE_W    = 4,
  parameter int NIBBLES     = 4,
  parameter int MATCH_CNT_W = 8
) (
  input  logic     clock,
  input  logic     reset,
  cypher_if.slave  bus
);
  localparam int CW     = NIBBLE_W * NIBBLES;
  localparam int FILL_W = $clog2(NIBBLES + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(NIBBLES);

  typedef enum logic [1:0] {
    UNARMED = 2'd0,
    ARMED   = 2'd1,
    MATCHED = 2'd2,
    LOCKED  = 2'd3
  } state_t;

  state_t            state, state_next;
  logic [CW-1:0]     cypher_reg;
  logic [CW-1:0]     window;
  logic [FILL_W-1:0] fill, fill_next;

  logic load, frozen, shift_en, cmp_en, hit, miss, out_en;

`ifdef CYPHER_MISMATCH_LOCK_EN
  logic [1:0] miss_cnt;
`endif

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    load       = bus.cypher_register_enable;
    frozen     = (state == LOCKED);
    shift_en   = !load && bus.input_register_enable && bus.nibble_valid && !frozen;
    cmp_en     = !load && bus.compare_enable && (fill == FILL_FULL) &&
                 ((state == ARMED) || (state == MATCHED));
    hit        = cmp_en && (window == cypher_reg);
    miss       = cmp_en && !hit;
    out_en     = bus.output_enable && !frozen;

    fill_next  = fill;
    if (load)
      fill_next = '0;
    else if (shift_en && (fill != FILL_FULL))
      fill_next = fill + 1'b1;

    state_next = state;
    if (load)
      state_next = ARMED;
    else if (hit)
      state_next = MATCHED;
`ifdef CYPHER_MISMATCH_LOCK_EN
    else if (miss && (miss_cnt == 2'd2))
      state_next = LOCKED;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= UNARMED;
      cypher_reg      <= '0;
      window          <= '0;
      fill            <= '0;
      bus.armed       <= 1'b0;
      bus.window_full <= 1'b0;
      bus.match       <= 1'b0;
      bus.match_seen  <= 1'b0;
      bus.match_count <= '0;
      bus.data_out    <= '0;
      bus.out_valid   <= 1'b0;
    end else begin
      state           <= state_next;
      fill            <= fill_next;
      bus.armed       <= (state_next == ARMED) || (state_next == MATCHED);
      bus.window_full <= (fill_next == FILL_FULL);
      bus.match       <= hit;
      bus.out_valid   <= out_en;

      if (load) begin
        cypher_reg <= bus.cypher_in;
        window     <= '0;
      end else if (shift_en) begin
        // Oldest nibble leaves from the MSBs, newest enters at the LSBs.
        window <= {window[CW-NIBBLE_W-1:0], bus.nibble_in};
      end

      if (load)
        bus.match_seen <= 1'b0;
      else if (hit)
        bus.match_seen <= 1'b1;

      if (hit && (bus.match_count != {MATCH_CNT_W{1'b1}}))
        bus.match_count <= bus.match_count + 1'b1;

      // Snapshot takes the pre-edge window, so a same-cycle shift is not visible here.
      if (out_en)
        bus.data_out <= window;
    end
  end

`ifdef CYPHER_MISMATCH_LOCK_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      miss_cnt   <= 2'd0;
      bus.locked <= 1'b0;
    end else begin
      bus.locked <= (state_next == LOCKED);
      if (load || hit)
        miss_cnt <= 2'd0;
      else if (miss && (miss_cnt != 2'd3))
        miss_cnt <= miss_cnt + 2'd1;
    end
  end
`else
  assign bus.locked = 1'b0;
`endif

endmodule

// File: tb/tb_cypher_datapath.sv
// Self-checking bench for cypher_datapath: directed scenarios followed by biased random traffic,
// all compared against a nibble-history reference model.
module tb_cypher_datapath;
  logic clock = 1'b0;
  logic reset = 1'b0;

  cypher_if #(.NIBBLE_W(4), .NIBBLES(4), .MATCH_CNT_W(8)) bus ();

  cypher_datapath #(.NIBBLE_W(4), .NIBBLES(4), .MATCH_CNT_W(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int fails  = 0;

  // Reference model: cypher, history of the last four accepted nibbles, and status flags.
  bit [15:0] m_cypher;
  bit [3:0]  m_q[$];
  bit        m_loaded, m_locked, m_seen, m_match, m_ov;
  int        m_hits, m_miss;
  bit [15:0] m_data;

  function automatic bit [15:0] window_of();
    bit [15:0] w = '0;
    foreach (m_q[i]) w = {w[11:0], m_q[i]};
    return w;
  endfunction

  task automatic model_reset();
    m_cypher = '0; m_q.delete();
    m_loaded = 0; m_locked = 0; m_seen = 0; m_match = 0; m_ov = 0;
    m_hits = 0; m_miss = 0; m_data = '0;
  endtask

  task automatic model_step();
    bit [15:0] w;
    bit        was_locked;
    w          = window_of();
    was_locked = m_locked;
    m_match    = 0;
    m_ov       = 0;
    if (bus.output_enable && !was_locked) begin
      m_ov   = 1;
      m_data = w;
    end
    if (bus.cypher_register_enable) begin
      m_cypher = bus.cypher_in;
      m_q.delete();
      m_seen = 0; m_loaded = 1; m_locked = 0; m_miss = 0;
    end else begin
      if (bus.compare_enable && m_q.size() == 4 && m_loaded && !was_locked) begin
        if (w == m_cypher) begin
          m_match = 1; m_seen = 1; m_miss = 0;
          if (m_hits < 255) m_hits++;
        end else begin
          m_miss++;
`ifdef CYPHER_MISMATCH_LOCK_EN
          if (m_miss == 3) m_locked = 1;
`endif
        end
      end
      if (bus.input_register_enable && bus.nibble_valid && !was_locked) begin
        m_q.push_back(bus.nibble_in);
        if (m_q.size() > 4) void'(m_q.pop_front());
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("armed",       32'(bus.armed),       32'(m_loaded && !m_locked));
    chk("window_full", 32'(bus.window_full), 32'(m_q.size() == 4));
    chk("match",       32'(bus.match),       32'(m_match));
    chk("match_seen",  32'(bus.match_seen),  32'(m_seen));
    chk("match_count", 32'(bus.match_count), 32'(m_hits));
    chk("out_valid",   32'(bus.out_valid),   32'(m_ov));
    chk("data_out",    32'(bus.data_out),    32'(m_data));
    chk("locked",      32'(bus.locked),      32'(m_locked));
  endtask

  // One clock: inputs already driven, model advanced on the edge, outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    check_all();
  endtask

  task automatic cyc(input bit ld, input bit [15:0] c, input bit sh, input bit [3:0] n,
                     input bit ce, input bit oe);
    bus.cypher_register_enable = ld;
    bus.cypher_in              = c;
    bus.input_register_enable  = sh;
    bus.nibble_valid           = sh;
    bus.nibble_in              = n;
    bus.compare_enable         = ce;
    bus.output_enable          = oe;
    tick();
  endtask

  task automatic load(input bit [15:0] c);  cyc(1, c, 0, 4'h0, 0, 0); endtask
  task automatic shift(input bit [3:0] n);  cyc(0, 16'h0, 1, n, 0, 0); endtask
  task automatic compare();                 cyc(0, 16'h0, 0, 4'h0, 1, 0); endtask
  task automatic snap();                    cyc(0, 16'h0, 0, 4'h0, 0, 1); endtask
  task automatic shift4(input bit [15:0] w);
    for (int i = 3; i >= 0; i--) shift(w[4*i +: 4]);
  endtask

  bit [15:0] r_cyp;
  int        r_idx;

  initial begin
    model_reset();
    bus.cypher_register_enable = 0; bus.cypher_in = '0;
    bus.input_register_enable = 0; bus.nibble_valid = 0; bus.nibble_in = '0;
    bus.compare_enable = 0; bus.output_enable = 0;
    repeat (2) @(posedge clock);
    #1;
    check_all();
    @(negedge clock);
    reset = 1'b1;

    // T1: asynchronous reset in the middle of activity, then compares before any load.
    load(16'h1111);
    shift4(16'h1111);
    bus.compare_enable = 1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    model_reset();
    chk("t1_rst_match", 32'(bus.match),       32'h0);
    chk("t1_rst_armed", 32'(bus.armed),       32'h0);
    chk("t1_rst_full",  32'(bus.window_full), 32'h0);
    chk("t1_rst_count", 32'(bus.match_count), 32'h0);
    chk("t1_rst_seen",  32'(bus.match_seen),  32'h0);
    @(posedge clock);
    #1;
    chk("t1_rst_held_match", 32'(bus.match), 32'h0);
    @(negedge clock);
    reset = 1'b1;
    shift4(16'h0000);
    compare();
    compare();
    chk("t1_unarmed_no_match", 32'(bus.match), 32'h0);

    // T2: basic hit.
    load(16'hA5C3);
    shift4(16'hA5C3);
    chk("t2_full", 32'(bus.window_full), 32'h1);
    compare();
    chk("t2_match", 32'(bus.match),       32'h1);
    chk("t2_seen",  32'(bus.match_seen),  32'h1);
    chk("t2_count", 32'(bus.match_count), 32'h1);

    // T3: sliding miss then re-hit.
    shift(4'h7);
    snap();
    chk("t3_window", 32'(bus.data_out), 32'h5C37);
    compare();
    chk("t3_miss", 32'(bus.match), 32'h0);
    shift4(16'hA5C3);
    compare();
    chk("t3_hit",   32'(bus.match),       32'h1);
    chk("t3_count", 32'(bus.match_count), 32'h2);

    // T4: partial window, then load colliding with shift and compare.
    load(16'hA5C3);
    shift(4'hA); shift(4'h5); shift(4'hC);
    compare();
    chk("t4_partial_match", 32'(bus.match),       32'h0);
    chk("t4_partial_full",  32'(bus.window_full), 32'h0);
    shift(4'h3);
    cyc(1, 16'hA5C3, 1, 4'h9, 1, 0);
    chk("t4_load_wins_match", 32'(bus.match), 32'h0);
    snap();
    chk("t4_load_wins_window", 32'(bus.data_out),    32'h0);
    chk("t4_load_wins_full",   32'(bus.window_full), 32'h0);

    // T5: counter saturation, output snapshot, shift+compare+output in one cycle.
    shift4(16'hA5C3);
    repeat (260) compare();
    chk("t5_saturated", 32'(bus.match_count), 32'hFF);
    snap();
    chk("t5_data", 32'(bus.data_out),  32'hA5C3);
    chk("t5_ov",   32'(bus.out_valid), 32'h1);
    cyc(0, 16'h0, 1, 4'h4, 1, 1);
    chk("t5_same_cycle_match", 32'(bus.match),    32'h1);
    chk("t5_same_cycle_data",  32'(bus.data_out), 32'hA5C3);
    snap();
    chk("t5_slid_window", 32'(bus.data_out), 32'h5C34);

`ifdef CYPHER_MISMATCH_LOCK_EN
    // T6: three consecutive misses lock; locked unit ignores traffic until reload.
    load(16'hA5C3);
    shift4(16'hA5C3);
    shift(4'h0);
    compare(); compare();
    chk("t6_not_yet_locked", 32'(bus.locked), 32'h0);
    compare();
    chk("t6_locked", 32'(bus.locked), 32'h1);
    chk("t6_disarmed", 32'(bus.armed), 32'h0);
    shift4(16'hA5C3);
    compare();
    chk("t6_ignored_match", 32'(bus.match), 32'h0);
    snap();
    chk("t6_ignored_ov", 32'(bus.out_valid), 32'h0);
    load(16'h1234);
    chk("t6_unlocked", 32'(bus.locked), 32'h0);
    chk("t6_rearmed",  32'(bus.armed),  32'h1);
`endif

    // Random phase: nibbles biased toward the loaded cypher so hits occur regularly.
    r_cyp = 16'hA5C3;
    r_idx = 0;
    load(r_cyp);
    for (int k = 0; k < 2000; k++) begin
      bit        ld, ire, nv;
      bit [15:0] c;
      bit [3:0]  n;
      ld  = ($urandom_range(0, 39) == 0);
      c   = ($urandom_range(0, 1) == 0) ? 16'hA5C3 : 16'($urandom);
      ire = ($urandom_range(0, 3) != 0);
      nv  = ($urandom_range(0, 3) != 0);
      n   = ($urandom_range(0, 3) != 0) ? r_cyp[4*(3-r_idx) +: 4] : 4'($urandom);
      bus.cypher_register_enable = ld;
      bus.cypher_in              = c;
      bus.input_register_enable  = ire;
      bus.nibble_valid           = nv;
      bus.nibble_in              = n;
      bus.compare_enable         = $urandom_range(0, 1) != 0;
      bus.output_enable          = $urandom_range(0, 4) == 0;
      if (ld) begin
        r_cyp = c;
        r_idx = 0;
      end else if (ire && nv) begin
        r_idx = (r_idx + 1) % 4;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
